// File: rtl/clause_len_counter.sv
// clause_len_counter
//   Counts the literals present in one clause word of the SAT bin engine.
//   Each variable occupies two bits: 2'b00 absent, 2'b01/2'b10 present
//   (polarity ignored), 2'b11 illegal (counted as present, flagged).
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset (registered path only)
//   clause_i    clause word, literal k = clause_i[2k+1:2k]
//   valid_i     qualifies clause_i for the registered path
//   len_o       combinational literal count, saturating at all ones
//   lit_mask_o  combinational, bit k set when literal k != 2'b00
//   len_q_o     len_o captured when valid_i
//   valid_o     valid_i delayed one cycle
//   empty_o     captured length == 0
//   unit_o      captured length == 1
//   bad_enc_o   captured word contained a 2'b11 literal
module clause_len_counter #(
  parameter int NUM_VARS = 8,
  parameter int WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NUM_VARS-1:0]   clause_i,
  input  logic                    valid_i,
  output logic [WIDTH-1:0]        len_o,
  output logic [NUM_VARS-1:0]     lit_mask_o,
  output logic [WIDTH-1:0]        len_q_o,
  output logic                    valid_o,
  output logic                    empty_o,
  output logic                    unit_o,
  output logic                    bad_enc_o
);

  localparam int unsigned LEN_MAX = (32'd1 << WIDTH) - 32'd1;

  // Clamp a raw count into the WIDTH-bit output range.
  function automatic logic [WIDTH-1:0] sat_len(input int unsigned cnt);
    if (cnt > LEN_MAX) begin
      return {WIDTH{1'b1}};
    end
    return cnt[WIDTH-1:0];
  endfunction

  int unsigned            cnt_p0;
  logic                   bad_p0;
  logic [WIDTH-1:0]       len_p1;
  logic                   vld_p1;
  logic                   empty_p1;
  logic                   unit_p1;
  logic                   bad_p1;

  // Stage p0: combinational decode and popcount of the incoming word.
  always_comb begin
    lit_mask_o = '0;
    cnt_p0     = 0;
    bad_p0     = 1'b0;
    for (int k = 0; k < NUM_VARS; k++) begin
      lit_mask_o[k] = |clause_i[2*k +: 2];
      cnt_p0        = cnt_p0 + 32'(lit_mask_o[k]);
      bad_p0        = bad_p0 | (&clause_i[2*k +: 2]);
    end
  end

  assign len_o = sat_len(cnt_p0);

  // Stage p1: captured result; reset has priority over a coincident valid_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      len_p1   <= '0;
      empty_p1 <= 1'b0;
      unit_p1  <= 1'b0;
      bad_p1   <= 1'b0;
    end else begin
      vld_p1 <= valid_i;
      if (valid_i) begin
        len_p1   <= len_o;
        empty_p1 <= (len_o == '0);
        unit_p1  <= (len_o == WIDTH'(1));
        bad_p1   <= bad_p0;
      end
    end
  end

  assign len_q_o   = len_p1;
  assign valid_o   = vld_p1;
  assign empty_o   = empty_p1;
  assign unit_o    = unit_p1;
  assign bad_enc_o = bad_p1;

endmodule

// File: tb/tb_clause_len_counter.sv
module tb_clause_len_counter;

  localparam int NV = 8;

  typedef struct packed {
    logic [3:0] len;
    logic       empty;
    logic       unit;
    logic       bad;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [2*NV-1:0] clause_i;
  logic            valid_i;
  logic [3:0]      len_o;
  logic [NV-1:0]   lit_mask_o;
  logic [3:0]      len_q_o;
  logic            valid_o;
  logic            empty_o;
  logic            unit_o;
  logic            bad_enc_o;

  logic [1:0]      s_len_o;
  logic [NV-1:0]   s_lit_mask_o;
  logic [1:0]      s_len_q_o;
  logic            s_valid_o;
  logic            s_empty_o;
  logic            s_unit_o;
  logic            s_bad_enc_o;

  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];
  exp_t hold;

  clause_len_counter #(.NUM_VARS(NV), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .clause_i(clause_i), .valid_i(valid_i),
    .len_o(len_o), .lit_mask_o(lit_mask_o), .len_q_o(len_q_o),
    .valid_o(valid_o), .empty_o(empty_o), .unit_o(unit_o),
    .bad_enc_o(bad_enc_o)
  );

  // Narrow-output instance so saturation is reachable.
  clause_len_counter #(.NUM_VARS(NV), .WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .clause_i(clause_i), .valid_i(valid_i),
    .len_o(s_len_o), .lit_mask_o(s_lit_mask_o), .len_q_o(s_len_q_o),
    .valid_o(s_valid_o), .empty_o(s_empty_o), .unit_o(s_unit_o),
    .bad_enc_o(s_bad_enc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned ref_count(input logic [2*NV-1:0] c);
    int unsigned n = 0;
    for (int k = 0; k < NV; k++)
      if (c[2*k +: 2] != 2'b00) n++;
    return n;
  endfunction

  function automatic logic [NV-1:0] ref_mask(input logic [2*NV-1:0] c);
    logic [NV-1:0] m = '0;
    for (int k = 0; k < NV; k++)
      m[k] = (c[2*k +: 2] != 2'b00);
    return m;
  endfunction

  function automatic logic ref_bad(input logic [2*NV-1:0] c);
    logic b = 1'b0;
    for (int k = 0; k < NV; k++)
      if (c[2*k +: 2] == 2'b11) b = 1'b1;
    return b;
  endfunction

  // One cycle: apply inputs, check the combinational outputs, clock once,
  // then check the registered outputs against the scoreboard.
  task automatic drive(input logic [2*NV-1:0] c, input logic v, input logic r);
    exp_t        e;
    int unsigned n;
    clause_i = c;
    valid_i  = v;
    rst      = r;
    #1;
    n = ref_count(c);
    check("len_o", 32'(len_o), (n > 15) ? 32'd15 : n);
    check("lit_mask_o", 32'(lit_mask_o), 32'(ref_mask(c)));
    check("sat_len_o", 32'(s_len_o), (n > 3) ? 32'd3 : n);
    if (r) begin
      exp_q.delete();
    end else if (v) begin
      e.len   = 4'(n);
      e.empty = (n == 0);
      e.unit  = (n == 1);
      e.bad   = ref_bad(c);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (r) hold = '0;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("valid_o", 32'(valid_o), 32'd1);
      hold = e;
    end else begin
      check("valid_o", 32'(valid_o), 32'd0);
    end
    check("len_q_o", 32'(len_q_o), 32'(hold.len));
    check("empty_o", 32'(empty_o), 32'(hold.empty));
    check("unit_o", 32'(unit_o), 32'(hold.unit));
    check("bad_enc_o", 32'(bad_enc_o), 32'(hold.bad));
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    hold     = '0;
    rst      = 1'b1;
    valid_i  = 1'b0;
    clause_i = '0;
    @(posedge clk);
    #1;
    // reset state
    drive(16'h0000, 1'b0, 1'b1);
    drive(16'h0000, 1'b0, 1'b1);
    // empty clause
    drive(16'h0000, 1'b1, 1'b0);
    // unit clause
    drive(16'b00_00_00_00_00_00_00_01, 1'b1, 1'b0);
    // full clause, 8 literals
    drive(16'b10_01_10_01_10_01_10_01, 1'b1, 1'b0);
    // illegal encoding
    drive(16'b00_11_00_00_10_00_00_00, 1'b1, 1'b0);
    // idle cycle: registered outputs hold
    drive(16'hFFFF, 1'b0, 1'b0);
    // back-to-back 3,5,0 then idle
    drive(16'h0015, 1'b1, 1'b0);
    drive(16'h0155, 1'b1, 1'b0);
    drive(16'h0000, 1'b1, 1'b0);
    drive(16'h5555, 1'b0, 1'b0);
    drive(16'h5555, 1'b0, 1'b0);
    // load a non-zero result, then reset with valid_i (len 4)
    drive(16'hAAFF, 1'b1, 1'b0);
    drive(16'h00AA, 1'b1, 1'b1);
    drive(16'h00AA, 1'b0, 1'b0);
    // reset mid-stream
    drive(16'h0002, 1'b1, 1'b0);
    drive(16'h000A, 1'b1, 1'b1);
    drive(16'h002A, 1'b1, 1'b0);
    // random traffic
    for (int i = 0; i < 40; i++)
      drive(16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    drive(16'h0000, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
